// File: rtl/reg_file_ptr_if.sv
// ============================================================================
// Module  : reg_file_ptr_if
// Brief   : Bus bundle for reg_file_ptr: write port, two read ports, pair pointer.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

interface reg_file_ptr_if #(
   parameter int DATA_W   = 8,
   parameter int NUM_REGS = 16
);
   localparam int SEL_W = $clog2(NUM_REGS);

   logic [SEL_W-1:0]  a_sel;
   logic [SEL_W-1:0]  b_sel;
   logic [DATA_W-1:0] wr_data;
   logic              wr_en;
   logic              inc;
   logic              dec;
   logic [DATA_W-1:0] a_data;
   logic [DATA_W-1:0] b_data;
   logic [DATA_W-1:0] c_data;
   logic              ptr_wrap;

   modport master (
      output a_sel, b_sel, wr_data, wr_en, inc, dec,
      input  a_data, b_data, c_data, ptr_wrap
   );

   modport slave (
      input  a_sel, b_sel, wr_data, wr_en, inc, dec,
      output a_data, b_data, c_data, ptr_wrap
   );
endinterface

`default_nettype wire

// File: rtl/reg_file_ptr.sv
// ============================================================================
// Module  : reg_file_ptr
// Brief   : Register file with one write port, two read ports and a +/-1 pair pointer.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module reg_file_ptr #(
   parameter int DATA_W   = 8,
   parameter int NUM_REGS = 16,
   parameter int BYPASS   = 0
) (
   input  logic           clk,
   input  logic           rst_n,
   reg_file_ptr_if.slave  bus
);
   localparam int SEL_W   = $clog2(NUM_REGS);
   localparam int c_depth = 1 << SEL_W;
   localparam logic [2*DATA_W-1:0] c_one = {{(2*DATA_W-1){1'b0}}, 1'b1};

   // Read view padded to the full select range so unused codes read as zero
   logic [DATA_W-1:0]   w_rd [c_depth];
   logic [SEL_W-1:0]    w_hi_sel;
   logic [2*DATA_W-1:0] w_pair;
   logic [2*DATA_W-1:0] w_pair_next;
   logic                w_collide;
   logic                w_step;
   logic                w_wrap;
   logic                r_ptr_wrap;

   always_comb begin
      w_hi_sel    = bus.b_sel | SEL_W'(1);
      w_pair      = {w_rd[w_hi_sel], w_rd[bus.b_sel]};
      w_collide   = bus.wr_en && ((bus.a_sel == bus.b_sel) || (bus.a_sel == w_hi_sel));
      w_step      = !bus.b_sel[0] && (bus.inc ^ bus.dec) && !w_collide;
      w_pair_next = bus.inc ? (w_pair + c_one) : (w_pair - c_one);
      w_wrap      = w_step && (bus.inc ? (&w_pair) : ~(|w_pair));
   end

   for (genvar i = 0; i < c_depth; i++) begin : g_reg
      if (i < NUM_REGS) begin : g_live
         localparam logic [SEL_W-1:0] c_idx = SEL_W'(i);
         logic [DATA_W-1:0] r_q;

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               r_q <= '0;
            end else if (bus.wr_en && (bus.a_sel == c_idx)) begin
               r_q <= bus.wr_data;
            end else if (w_step && (bus.b_sel == c_idx)) begin
               r_q <= w_pair_next[DATA_W-1:0];
            end else if (w_step && (w_hi_sel == c_idx)) begin
               r_q <= w_pair_next[2*DATA_W-1:DATA_W];
            end
         end

         assign w_rd[i] = r_q;
      end else begin : g_pad
         assign w_rd[i] = '0;
      end
   end

   if (BYPASS != 0) begin : g_bypass
      assign bus.a_data = bus.wr_en ? bus.wr_data : w_rd[bus.a_sel];
      assign bus.b_data = (bus.wr_en && (bus.a_sel == bus.b_sel)) ? bus.wr_data
                                                                  : w_rd[bus.b_sel];
   end else begin : g_direct
      assign bus.a_data = w_rd[bus.a_sel];
      assign bus.b_data = w_rd[bus.b_sel];
   end

   // High byte of the pointer only exists for an even low select
   assign bus.c_data = bus.b_sel[0] ? '0 : w_rd[w_hi_sel];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_ptr_wrap <= 1'b0;
      end else begin
         r_ptr_wrap <= w_wrap;
      end
   end

   assign bus.ptr_wrap = r_ptr_wrap;

endmodule

`default_nettype wire

// File: tb/tb_reg_file_ptr.sv
// ============================================================================
// Module  : tb_reg_file_ptr
// Brief   : Self-checking bench for reg_file_ptr (BYPASS=0 and BYPASS=1 side by side).
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_reg_file_ptr;
   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [3:0] a_sel = '0;
   logic [3:0] b_sel = '0;
   logic [7:0] wr_data = '0;
   logic       wr_en = 1'b0;
   logic       inc = 1'b0;
   logic       dec = 1'b0;

   int n_cmp = 0;
   int n_bad = 0;
   bit chk_on = 1'b0;

   always #5 clk = ~clk;

   reg_file_ptr_if #(.DATA_W(8), .NUM_REGS(16)) bus0 ();
   reg_file_ptr_if #(.DATA_W(8), .NUM_REGS(16)) bus1 ();

   assign bus0.a_sel = a_sel;   assign bus1.a_sel = a_sel;
   assign bus0.b_sel = b_sel;   assign bus1.b_sel = b_sel;
   assign bus0.wr_data = wr_data; assign bus1.wr_data = wr_data;
   assign bus0.wr_en = wr_en;   assign bus1.wr_en = wr_en;
   assign bus0.inc = inc;       assign bus1.inc = inc;
   assign bus0.dec = dec;       assign bus1.dec = dec;

   reg_file_ptr #(.DATA_W(8), .NUM_REGS(16), .BYPASS(0)) u_dut0 (
      .clk(clk), .rst_n(rst_n), .bus(bus0));
   reg_file_ptr #(.DATA_W(8), .NUM_REGS(16), .BYPASS(1)) u_dut1 (
      .clk(clk), .rst_n(rst_n), .bus(bus1));

   // Reference: plain array of bytes, pair handled as a 16-bit integer
   logic [7:0] m_reg [16] = '{default: 8'h00};
   logic       m_wrap = 1'b0;

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
      end
   endtask

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 16; i++) m_reg[i] <= 8'h00;
         m_wrap <= 1'b0;
      end else begin
         int         lo;
         int         hi;
         int         pair;
         bit         step;
         lo   = int'(b_sel);
         hi   = lo + 1;
         pair = int'(m_reg[hi % 16]) * 256 + int'(m_reg[lo]);
         step = (lo % 2 == 0) && (inc != dec) &&
                !(wr_en && (int'(a_sel) == lo || int'(a_sel) == hi));
         if (step) begin
            int np;
            np = inc ? (pair + 1) % 65536 : (pair + 65535) % 65536;
            m_reg[lo] <= 8'(np % 256);
            m_reg[hi] <= 8'(np / 256);
            m_wrap    <= inc ? (pair == 65535) : (pair == 0);
         end else begin
            m_wrap <= 1'b0;
         end
         if (wr_en) m_reg[a_sel] <= wr_data;
      end
   end

   always @(negedge clk) begin
      if (chk_on) begin
         logic [7:0] ea, eb, ec, ea1, eb1;
         ea  = m_reg[a_sel];
         eb  = m_reg[b_sel];
         ec  = b_sel[0] ? 8'h00 : m_reg[b_sel | 4'd1];
         ea1 = wr_en ? wr_data : ea;
         eb1 = (wr_en && a_sel == b_sel) ? wr_data : eb;
         chk("m_a_data",   16'(bus0.a_data),   16'(ea));
         chk("m_b_data",   16'(bus0.b_data),   16'(eb));
         chk("m_c_data",   16'(bus0.c_data),   16'(ec));
         chk("m_ptr_wrap", 16'(bus0.ptr_wrap), 16'(m_wrap));
         chk("m_a_byp",    16'(bus1.a_data),   16'(ea1));
         chk("m_b_byp",    16'(bus1.b_data),   16'(eb1));
         chk("m_c_byp",    16'(bus1.c_data),   16'(ec));
         chk("m_wrap_byp", 16'(bus1.ptr_wrap), 16'(m_wrap));
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      wr_en = 1'b0; inc = 1'b0; dec = 1'b0;
   endtask

   task automatic wr(input logic [3:0] a, input logic [7:0] d);
      idle();
      wr_en = 1'b1; a_sel = a; wr_data = d;
      tick();
      idle();
   endtask

   task automatic step_pair(input logic [3:0] b, input logic i, input logic d);
      idle();
      b_sel = b; inc = i; dec = d;
      tick();
      idle();
   endtask

   initial begin
      tick(); tick();
      #2 rst_n = 1'b1;
      chk_on = 1'b1;
      tick();
      chk("reset_a", 16'(bus0.a_data), 16'h0000);
      chk("reset_wrap", 16'(bus0.ptr_wrap), 16'h0000);

      // 1: async clear between edges
      wr(4'd3, 8'h5A);
      wr(4'd7, 8'h11);
      a_sel = 4'd3;
      #2;
      chk("t1_pre", 16'(bus0.a_data), 16'h005A);
      rst_n = 1'b0;
      #1;
      chk("t1_async_clr", 16'(bus0.a_data), 16'h0000);
      a_sel = 4'd7;
      #1;
      chk("t1_r7_clr", 16'(bus0.a_data), 16'h0000);
      tick();
      #2 rst_n = 1'b1;
      tick();

      // 2: write visibility and bypass
      wr_en = 1'b1; a_sel = 4'd3; wr_data = 8'hA5;
      #1;
      chk("t2_byp_same", 16'(bus1.a_data), 16'h00A5);
      chk("t2_nobyp_same", 16'(bus0.a_data), 16'h0000);
      tick();
      idle();
      chk("t2_next", 16'(bus0.a_data), 16'h00A5);

      // 3: carry and true borrow across bytes
      wr(4'd0, 8'hFF);
      wr(4'd1, 8'h00);
      step_pair(4'd0, 1'b1, 1'b0);
      chk("t3_inc_lo", 16'(bus0.b_data), 16'h0000);
      chk("t3_inc_hi", 16'(bus0.c_data), 16'h0001);
      chk("t3_inc_wrap", 16'(bus0.ptr_wrap), 16'h0000);
      step_pair(4'd0, 1'b0, 1'b1);
      chk("t3_dec", {8'(bus0.c_data), 8'(bus0.b_data)}, 16'h00FF);

      // 4: wrap both ways
      wr(4'd4, 8'hFF);
      wr(4'd5, 8'hFF);
      step_pair(4'd4, 1'b1, 1'b0);
      chk("t4_inc_pair", {8'(bus0.c_data), 8'(bus0.b_data)}, 16'h0000);
      chk("t4_inc_wrap", 16'(bus0.ptr_wrap), 16'h0001);
      tick();
      chk("t4_wrap_1cyc", 16'(bus0.ptr_wrap), 16'h0000);
      step_pair(4'd4, 1'b0, 1'b1);
      chk("t4_dec_pair", {8'(bus0.c_data), 8'(bus0.b_data)}, 16'hFFFF);
      chk("t4_dec_wrap", 16'(bus0.ptr_wrap), 16'h0001);

      // 5: collision suppresses step; disjoint write runs in parallel
      wr(4'd4, 8'h10);
      wr(4'd5, 8'h00);
      b_sel = 4'd4; inc = 1'b1; wr_en = 1'b1; a_sel = 4'd5; wr_data = 8'h12;
      tick();
      idle();
      chk("t5_coll_pair", {8'(bus0.c_data), 8'(bus0.b_data)}, 16'h1210);
      wr(4'd5, 8'h00);
      b_sel = 4'd4; inc = 1'b1; wr_en = 1'b1; a_sel = 4'd9; wr_data = 8'h12;
      tick();
      idle();
      chk("t5_par_pair", {8'(bus0.c_data), 8'(bus0.b_data)}, 16'h0011);
      chk("t5_par_r9", 16'(bus0.a_data), 16'h0012);

      // 6: odd select and inc+dec are no-ops
      b_sel = 4'd3; inc = 1'b1;
      #1;
      chk("t6_odd_c", 16'(bus0.c_data), 16'h0000);
      tick();
      idle();
      chk("t6_odd_r3", 16'(bus0.b_data), 16'h00A5);
      chk("t6_odd_wrap", 16'(bus0.ptr_wrap), 16'h0000);
      step_pair(4'd2, 1'b1, 1'b1);
      chk("t6_both_pair", {8'(bus0.c_data), 8'(bus0.b_data)}, 16'hA500);
      chk("t6_both_wrap", 16'(bus0.ptr_wrap), 16'h0000);

      // Randomised traffic with occasional mid-cycle resets
      for (int n = 0; n < 3000; n++) begin
         int r;
         a_sel   = 4'($urandom_range(0, 15));
         b_sel   = 4'($urandom_range(0, 15));
         if ($urandom_range(0, 9) < 7) b_sel[0] = 1'b0;
         wr_data = 8'($urandom);
         r       = $urandom_range(0, 99);
         if (r < 8)       wr_data = 8'hFF;
         else if (r < 16) wr_data = 8'h00;
         wr_en   = ($urandom_range(0, 3) == 0);
         inc     = ($urandom_range(0, 9) < 4);
         dec     = ($urandom_range(0, 9) < 4);
         if ($urandom_range(0, 499) == 0) begin
            #1 rst_n = 1'b0;
            #5 rst_n = 1'b1;
         end
         tick();
      end
      idle();
      tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

`default_nettype wire
